// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential multiply-and-display engine.
//   state_t     : controller states (IDLE -> MULT -> CONV -> DONE -> IDLE)
//   SEG_BLANK   : active-low {g,f,e,d,c,b,a} code with all segments off
//   SEG_MINUS   : active-low code lighting only segment g
//   DIGIT_SEG   : active-low codes for decimal digits 0..9, indexed by digit
//   min_digits  : decimal digits needed for the largest product magnitude
package seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MULT,
    ST_CONV,
    ST_DONE
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // Element [0] is the rightmost entry.
  localparam logic [9:0][6:0] DIGIT_SEG = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Largest magnitude is 2^(2n-2) for two's-complement operands
  // (-2^(n-1) squared), otherwise (2^n - 1)^2.
  function automatic int min_digits(input int nbits, input bit is_signed);
    logic [127:0] m;
    logic [127:0] full;
    int           d;
    full = (128'd1 << nbits) - 128'd1;
    if (is_signed) m = 128'd1 << (2 * nbits - 2);
    else           m = full * full;
    d = 1;
    while (m >= 128'd10) begin
      m = m / 128'd10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/seg7_digit.sv
// Combinational BCD nibble to seven-segment encoder.
//   bcd   : decimal digit 0..9 (codes above 9 show blank)
//   blank : forces the digit dark (leading-zero suppression)
//   seg   : active-low segments, bit order {g,f,e,d,c,b,a}
module seg7_digit
  import seq_mult_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (bcd <= 4'd9)) seg = DIGIT_SEG[bcd];
  end

endmodule

// File: rtl/seq_mult_bcd_display.sv
// Sequential shift-add multiplier with double-dabble BCD conversion and a
// held seven-segment display of the last result.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   start        : request, sampled only while idle
//   multiplier   : operand A, captured on the accepted start edge
//   multiplicand : operand B, captured on the accepted start edge
//   busy         : high from the accepted start until the result publishes
//   ready        : one-cycle pulse with each newly published result
//   product      : last product (two's-complement when SIGNED)
//   seg_out      : NDIGITS active-low digits, digit k at [7k+6:7k], k=0 units
//   sign_seg     : minus sign for a negative nonzero product, else blank
module seq_mult_bcd_display
  import seq_mult_pkg::*;
#(
  parameter int NBITS   = 8,
  parameter int NDIGITS = 5,
  parameter bit SIGNED  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NBITS-1:0]       multiplier,
  input  logic [NBITS-1:0]       multiplicand,
  output logic                   busy,
  output logic                   ready,
  output logic [2*NBITS-1:0]     product,
  output logic [7*NDIGITS-1:0]   seg_out,
  output logic [6:0]             sign_seg
);

  localparam int PW    = 2 * NBITS;
  localparam int BW    = 4 * NDIGITS;
  localparam int DW    = BW + PW;
  localparam int CNT_W = $clog2(PW + 1);

  if (NBITS < 2) begin : g_nbits_check
    $fatal(1, "seq_mult_bcd_display: NBITS must be at least 2");
  end
  if (NDIGITS < min_digits(NBITS, SIGNED)) begin : g_ndigits_check
    $fatal(1, "seq_mult_bcd_display: NDIGITS too small for the largest product");
  end

  function automatic logic [7*NDIGITS-1:0] reset_display();
    logic [7*NDIGITS-1:0] s;
    for (int k = 0; k < NDIGITS; k++) s[7*k +: 7] = (k == 0) ? DIGIT_SEG[0] : SEG_BLANK;
    return s;
  endfunction

  localparam logic [7*NDIGITS-1:0] RESET_SEG = reset_display();

  // Operand magnitude; negating -2^(NBITS-1) wraps to the correct unsigned value.
  function automatic logic [NBITS-1:0] mag_of(input logic signed [NBITS-1:0] v);
    logic [NBITS-1:0] m;
    m = v;
    if (SIGNED && (v < 0)) m = -v;
    return m;
  endfunction

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  function automatic logic [DW-1:0] dabble_step(input logic [DW-1:0] r);
    logic [DW-1:0] t;
    t = r;
    for (int k = 0; k < NDIGITS; k++) begin
      if (t[PW+4*k +: 4] >= 4'd5) t[PW+4*k +: 4] = t[PW+4*k +: 4] + 4'd3;
    end
    return {t[DW-2:0], 1'b0};
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [NBITS-1:0] mplier;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_next;
  logic             neg_sign;
  logic [DW-1:0]    dd;
  logic             negative;
  logic [NDIGITS-1:0]   digit_blank;
  logic [7*NDIGITS-1:0] seg_next;

  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  assign negative = SIGNED && neg_sign && (acc != '0);

  // Datapath registers carry no reset; the controller decides when they matter.
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: begin
        if (start) begin
          mplier   <= mag_of(multiplier);
          mcand    <= PW'(mag_of(multiplicand));
          acc      <= '0;
          neg_sign <= SIGNED && (multiplier[NBITS-1] ^ multiplicand[NBITS-1]);
        end
      end
      ST_MULT: begin
        acc    <= acc_next;
        mplier <= mplier >> 1;
        mcand  <= mcand << 1;
        // Seed the converter with the final sum on the last multiply step.
        if (cnt == '0) dd <= {{BW{1'b0}}, acc_next};
      end
      ST_CONV: begin
        dd <= dabble_step(dd);
      end
      default: ;
    endcase
  end

  // Leading-zero blanking: a digit is dark until a nonzero digit at or above it.
  always_comb begin
    logic lit;
    lit         = 1'b0;
    digit_blank = '0;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      if ((dd[PW+4*k +: 4] != 4'd0) || (k == 0)) lit = 1'b1;
      digit_blank[k] = !lit;
    end
  end

  for (genvar k = 0; k < NDIGITS; k++) begin : g_digit
    seg7_digit u_digit (
      .bcd   (dd[PW+4*k +: 4]),
      .blank (digit_blank[k]),
      .seg   (seg_next[7*k +: 7])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      product  <= '0;
      seg_out  <= RESET_SEG;
      sign_seg <= SEG_BLANK;
    end else begin
      ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_MULT;
            cnt   <= CNT_W'(NBITS - 1);
            busy  <= 1'b1;
          end
        end
        ST_MULT: begin
          if (cnt == '0) begin
            state <= ST_CONV;
            cnt   <= CNT_W'(PW - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_CONV: begin
          if (cnt == '0) state <= ST_DONE;
          else           cnt   <= cnt - 1'b1;
        end
        ST_DONE: begin
          product  <= negative ? (~acc + 1'b1) : acc;
          seg_out  <= seg_next;
          sign_seg <= negative ? SEG_MINUS : SEG_BLANK;
          ready    <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_bcd_display.sv
// Self-checking bench for seq_mult_bcd_display (NBITS=8, NDIGITS=5, SIGNED=1).
// Expected results are queued when an operation starts and compared by a
// monitor whenever the design pulses ready.
module tb_seq_mult_bcd_display;

  localparam int NBITS   = 8;
  localparam int NDIGITS = 5;
  localparam int LAT     = 3 * NBITS + 1;
  localparam logic [34:0] RESET_SEG = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [NBITS-1:0]     multiplier;
  logic [NBITS-1:0]     multiplicand;
  logic                 busy;
  logic                 ready;
  logic [2*NBITS-1:0]   product;
  logic [7*NDIGITS-1:0] seg_out;
  logic [6:0]           sign_seg;

  seq_mult_bcd_display #(
    .NBITS   (NBITS),
    .NDIGITS (NDIGITS),
    .SIGNED  (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .busy         (busy),
    .ready        (ready),
    .product      (product),
    .seg_out      (seg_out),
    .sign_seg     (sign_seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] product;
    logic [34:0] seg;
    logic [6:0]  sign;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    int   sa, sb, p, tmp;
    exp_t e;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
    e.product = p[15:0];
    tmp = (p < 0) ? -p : p;
    e.seg = '0;
    for (int k = 0; k < 5; k++) begin
      e.seg[7*k +: 7] = ((k == 0) || (tmp != 0)) ? seg_tab[tmp % 10] : 7'h7F;
      tmp = tmp / 10;
    end
    e.sign = (p < 0) ? 7'h3F : 7'h7F;
    return e;
  endfunction

  always @(negedge clk) begin
    if (ready) begin
      if (sb_q.size() == 0) begin
        check_val("ready_without_op", ready, 1'b0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("product", product, e.product);
        check_val("seg_out", seg_out, e.seg);
        check_val("sign_seg", sign_seg, e.sign);
      end
    end
  end

  // Drive start for one edge (E0); returns #1 after E0.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    multiplier   = a;
    multiplicand = b;
    start        = 1'b1;
    sb_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val("busy_after_start", busy, 1'b1);
    check_val("ready_after_start", ready, 1'b0);
  endtask

  // Wait (bounded) for ready; elapsed is edges already spent since E0.
  task automatic wait_done(input int elapsed);
    int cycles;
    cycles = elapsed;
    while (!ready && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check_val("latency", cycles, LAT);
    check_val("busy_at_ready", busy, 1'b0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    start_op(a, b);
    wait_done(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    multiplier   = '0;
    multiplicand = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_busy", busy, 1'b0);
    check_val("reset_ready", ready, 1'b0);
    check_val("reset_product", product, 16'h0000);
    check_val("reset_seg", seg_out, RESET_SEG);
    check_val("reset_sign", sign_seg, 7'h7F);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases, issued back-to-back (start during the ready cycle).
    run_op(8'd12, 8'd11);
    run_op(8'hF9, 8'd9);      // -7 x 9
    run_op(8'h80, 8'h80);     // -128 x -128
    run_op(8'd0, 8'hFB);      // 0 x -5
    run_op(8'h7F, 8'h7F);     // 127 x 127
    run_op(8'h80, 8'h7F);     // -128 x 127
    run_op(8'hFF, 8'h01);     // -1 x 1

    repeat (4) @(posedge clk);
    #1;

    // Start during MULT is ignored; operand changes after E0 have no effect.
    start_op(8'd3, 8'd4);
    repeat (2) @(posedge clk);
    #1;
    multiplier   = 8'd5;
    multiplicand = 8'd5;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(3);
    repeat (6) @(posedge clk);
    #1;
    run_op(8'd5, 8'd5);

    for (int i = 0; i < 6; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      run_op(a, b);
    end

    // Reset mid-CONV aborts the operation.
    repeat (2) @(posedge clk);
    #1;
    start_op(8'd100, 8'hFD);
    repeat (NBITS + 4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_ready", ready, 1'b0);
    check_val("abort_product", product, 16'h0000);
    check_val("abort_seg", seg_out, RESET_SEG);
    check_val("abort_sign", sign_seg, 7'h7F);
    sb_q.delete();
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_val("abort_idle_busy", busy, 1'b0);

    run_op(8'hFF, 8'hFF);     // -1 x -1

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
